// File: rtl/adc_pkg.sv
// Shared types for the dual-slope ADC controller and its analog front-end model.
// Switch-mode decode and default datapath widths.
package adc_pkg;

  localparam int unsigned ACC_W_DEF = 40;
  localparam int unsigned VIN_W_DEF = 16;

  typedef enum logic [2:0] {
    MODE_HOLD,
    MODE_CHARGE,
    MODE_DISCHARGE,
    MODE_SHORT,
    MODE_FAULT
  } mode_e;

  function automatic mode_e decode_mode(
    input logic up,
    input logic dn,
    input logic sh
  );
    mode_e m;
    m = MODE_HOLD;
    if ($countones({up, dn, sh}) > 1) begin
      m = MODE_FAULT;
    end else begin
      unique case (1'b1)
        up:      m = MODE_CHARGE;
        dn:      m = MODE_DISCHARGE;
        sh:      m = MODE_SHORT;
        default: m = MODE_HOLD;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/adc_frontend_emulator_comparator_model.sv
// Hysteretic comparator on the integrator charge, followed by a
// preset-to-one delay line modelling comparator/board latency.
module comparator_model #(
  parameter int unsigned     ACC_W      = 40,
  parameter longint unsigned THRESH     = 0,
  parameter longint unsigned HYST       = 64,
  parameter int unsigned     COMP_DELAY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ACC_W-1:0] charge,
  output logic             comparator
);

  localparam logic [ACC_W:0] TRIP = THRESH[ACC_W:0];
  localparam logic [ACC_W:0] REL  = TRIP + HYST[ACC_W:0];

  logic           cmp_raw;
  logic [ACC_W:0] q;

  assign q = {1'b0, charge};

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_raw <= 1'b1;
    end else if (q <= TRIP) begin
      cmp_raw <= 1'b1;
    end else if (q > REL) begin
      cmp_raw <= 1'b0;
    end
  end

  generate
    if (COMP_DELAY == 0) begin : g_nodly
      assign comparator = cmp_raw;
    end else begin : g_dly
      logic [COMP_DELAY-1:0] dly;
      always_ff @(posedge clk) begin
        if (reset) begin
          dly <= '1;
        end else begin
          dly <= (dly << 1) | COMP_DELAY'(cmp_raw);
        end
      end
      assign comparator = dly[COMP_DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/adc_frontend_emulator.sv
// Digital stand-in for the dual-slope integrator, switches and comparator.
// Mode decode, saturating charge accumulator and sticky status flags.
module adc_frontend_emulator
  import adc_pkg::*;
#(
  parameter int unsigned     ACC_W          = ACC_W_DEF,
  parameter int unsigned     VIN_W          = VIN_W_DEF,
  parameter longint unsigned THRESH         = 0,
  parameter longint unsigned HYST           = 64,
  parameter longint unsigned DISCHARGE_STEP = 64'd1 << 20,
  parameter int unsigned     COMP_DELAY     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ramp_up_sw,
  input  logic             ramp_down_sw,
  input  logic             reset_cap_sw,
  input  logic [VIN_W-1:0] vin_code,
  input  logic [VIN_W-1:0] vref_code,
  output logic             comparator,
  output logic [ACC_W-1:0] charge,
  output logic             sat,
  output logic             fault
);

  localparam logic [ACC_W:0] STEP = DISCHARGE_STEP[ACC_W:0];

  mode_e          mode;
  logic [ACC_W:0] acc;
  logic [ACC_W:0] sum;
  logic [ACC_W:0] dif_ref;
  logic [ACC_W:0] dif_step;
  logic [ACC_W-1:0] nxt;
  logic           clamp;

  // Top bit of each ACC_W+1 result is the carry/borrow used for clamping.
  always_comb begin
    mode     = decode_mode(ramp_up_sw, ramp_down_sw, reset_cap_sw);
    acc      = {1'b0, charge};
    sum      = acc + (ACC_W+1)'(vin_code);
    dif_ref  = acc - (ACC_W+1)'(vref_code);
    dif_step = acc - STEP;
    clamp    = sum[ACC_W];
    nxt      = charge;
    unique case (mode)
      MODE_CHARGE:    nxt = clamp ? '1 : sum[ACC_W-1:0];
      MODE_DISCHARGE: nxt = dif_ref[ACC_W] ? '0 : dif_ref[ACC_W-1:0];
      MODE_SHORT:     nxt = dif_step[ACC_W] ? '0 : dif_step[ACC_W-1:0];
      default:        nxt = charge;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      charge <= '0;
      sat    <= 1'b0;
      fault  <= 1'b0;
    end else begin
      charge <= nxt;
      if (mode == MODE_CHARGE && clamp) begin
        sat <= 1'b1;
      end else if (reset_cap_sw &&
                   (mode == MODE_SHORT || mode == MODE_FAULT)) begin
        sat <= 1'b0;
      end
      if (mode == MODE_FAULT) begin
        fault <= 1'b1;
      end
    end
  end

  comparator_model #(
    .ACC_W      (ACC_W),
    .THRESH     (THRESH),
    .HYST       (HYST),
    .COMP_DELAY (COMP_DELAY)
  ) u_cmp (
    .clk        (clk),
    .reset      (reset),
    .charge     (charge),
    .comparator (comparator)
  );

endmodule

// File: tb/tb_adc_frontend_emulator.sv
// Scoreboard bench for the ADC front-end emulator.
// Narrow accumulator so saturation is reachable in a few hundred cycles.
module tb_adc_frontend_emulator;
  import adc_pkg::*;

  localparam int AW = 24;
  localparam longint FULL = (64'd1 << AW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic up = 1'b0;
  logic dn = 1'b0;
  logic sh = 1'b0;
  logic [15:0] vin = '0;
  logic [15:0] vref = '0;
  logic comparator;
  logic sat;
  logic fault;
  logic [AW-1:0] charge;

  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;

  typedef enum {K_CHG, K_CMP, K_SAT, K_FLT} kind_e;
  typedef struct {
    int     cyc;
    kind_e  k;
    longint v;
  } exp_t;
  exp_t sb[$];

  adc_frontend_emulator #(.ACC_W(AW), .VIN_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .ramp_up_sw   (up),
    .ramp_down_sw (dn),
    .reset_cap_sw (sh),
    .vin_code     (vin),
    .vref_code    (vref),
    .comparator   (comparator),
    .charge       (charge),
    .sat          (sat),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: retire every expectation due at this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        longint act;
        case (sb[i].k)
          K_CHG:   act = longint'(charge);
          K_CMP:   act = longint'(comparator);
          K_SAT:   act = longint'(sat);
          default: act = longint'(fault);
        endcase
        n_run++;
        if (act != sb[i].v || sb[i].cyc != cyc) begin
          n_fail++;
          $display("FAIL %s @cyc %0d (due %0d): got %0d want %0d",
                   sb[i].k.name(), cyc, sb[i].cyc, act, sb[i].v);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_at(input int d, input kind_e k, input longint v);
    exp_t e;
    e.cyc = cyc + d;
    e.k = k;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic sw(input logic u, input logic d, input logic s);
    up = u;
    dn = d;
    sh = s;
  endtask

  initial begin
    tick(3);
    exp_at(0, K_CHG, 0);
    exp_at(0, K_CMP, 1);
    exp_at(0, K_SAT, 0);
    exp_at(0, K_FLT, 0);
    reset = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      exp_at(i, K_CHG, 0);
      exp_at(i, K_CMP, 1);
    end
    exp_at(100, K_SAT, 0);
    exp_at(100, K_FLT, 0);
    tick(100);

    // Up 1000 x 100, then down at 400 per cycle.
    vin = 16'd100;
    sw(1, 0, 0);
    exp_at(3, K_CMP, 1);
    exp_at(4, K_CMP, 0);
    exp_at(1000, K_CHG, 100000);
    tick(1000);
    vref = 16'd400;
    sw(0, 1, 0);
    exp_at(249, K_CHG, 400);
    exp_at(250, K_CHG, 0);
    exp_at(252, K_CMP, 0);
    exp_at(253, K_CMP, 1);
    exp_at(255, K_CHG, 0);
    tick(255);

    // Hysteresis window with unit steps.
    vin = 16'd1;
    sw(1, 0, 0);
    exp_at(64, K_CHG, 64);
    exp_at(64, K_CMP, 1);
    exp_at(67, K_CMP, 1);
    exp_at(68, K_CMP, 0);
    exp_at(70, K_CHG, 70);
    tick(70);
    sw(0, 0, 1);
    exp_at(1, K_CHG, 0);
    exp_at(3, K_CMP, 0);
    exp_at(4, K_CMP, 1);
    tick(5);

    // Saturation at all-ones, then SHORT.
    vin = 16'hFFFF;
    sw(1, 0, 0);
    exp_at(256, K_CHG, 256 * 65535);
    exp_at(256, K_SAT, 0);
    exp_at(257, K_CHG, FULL);
    exp_at(257, K_SAT, 1);
    exp_at(260, K_CHG, FULL);
    exp_at(260, K_SAT, 1);
    tick(260);
    sw(0, 0, 1);
    exp_at(1, K_SAT, 0);
    exp_at(1, K_CHG, FULL - 1048576);
    exp_at(15, K_CHG, 1048575);
    exp_at(16, K_CHG, 0);
    tick(16);

    // Illegal switch combos.
    vin = 16'd500;
    sw(1, 0, 0);
    exp_at(4, K_CHG, 2000);
    tick(4);
    vref = 16'd100;
    sw(1, 1, 0);
    exp_at(1, K_CHG, 2000);
    exp_at(1, K_FLT, 1);
    tick(1);
    sw(0, 0, 0);
    exp_at(5, K_FLT, 1);
    exp_at(5, K_CHG, 2000);
    tick(5);
    sw(1, 0, 1);
    exp_at(1, K_CHG, 2000);
    exp_at(1, K_FLT, 1);
    tick(1);
    reset = 1'b1;
    sw(1, 0, 0);
    exp_at(1, K_CHG, 0);
    exp_at(1, K_FLT, 0);
    exp_at(1, K_SAT, 0);
    exp_at(1, K_CMP, 1);
    tick(1);
    reset = 1'b0;
    sw(0, 0, 0);
    tick(1);

    // vref = 0 freezes the charge in DISCHARGE.
    sw(1, 0, 0);
    exp_at(2, K_CHG, 1000);
    tick(2);
    vref = 16'd0;
    sw(0, 1, 0);
    exp_at(20, K_CHG, 1000);
    exp_at(20, K_CMP, 0);
    tick(20);
    sw(0, 0, 0);
    tick(3);

    if (sb.size() != 0) begin
      $display("FAIL scoreboard: %0d expectations never retired", sb.size());
      n_fail += sb.size();
      n_run += sb.size();
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
